sd_spi_response_tx: RTL and testbench

- Downstream stage of the SD-over-SPI slave command receiver. It serialises the card's reply onto the SPI data-out line (DO).
- Reply sequence: NCR filler bytes, then the R1 response byte, then optionally a data token, a data block of BLOCK_BYTES bytes and a 16-bit CRC.
- Runs in the system clock domain. The raw SPI clock is sampled as a level, and DO changes on detected SPI falling edges (SPI mode 0).

---
 rtl/sd_spi_response_tx.sv | 200 ++++++++++++++++++++
 tb/tb_sd_spi_response_tx.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_response_tx.sv
// SD-over-SPI reply serialiser: NCR filler, R1, optional token + data block + CRC, SPI mode 0.
// Optional macro SD_SPI_TX_CRC16_EN enables a real CRC16-CCITT; otherwise the CRC bytes are 0xFF.
module sd_spi_response_tx #(
    parameter int unsigned NCR_BYTES   = 1,
    parameter int unsigned BLOCK_BYTES = 512,
    parameter logic [7:0]  TOKEN       = 8'hFE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_SpiClk,
    input  logic       io_CS,
    input  logic       io_ReqValid,
    output logic       io_ReqReady,
    input  logic [7:0] io_ReqR1,
    input  logic       io_ReqData,
    input  logic       io_DataValid,
    input  logic [7:0] io_DataByte,
    output logic       io_DataReady,
    output logic       io_DO,
    output logic       io_Busy,
    output logic       io_Done,
    output logic       io_Underrun
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] NCR      = 3'd1;
    localparam logic [2:0] R1       = 3'd2;
    localparam logic [2:0] TOKEN_ST = 3'd3;
    localparam logic [2:0] DATA     = 3'd4;
    localparam logic [2:0] CRC      = 3'd5;

    localparam logic [9:0] NCR_LAST = 10'(NCR_BYTES - 1);
    localparam logic [9:0] BLK_LAST = 10'(BLOCK_BYTES - 1);

    logic [2:0] state_q, state_d;
    logic       sclk_q;
    logic       ready_q;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic [9:0] byte_q, byte_d;
    logic [7:0] r1_q, r1_d;
    logic       flag_q, flag_d;
    logic       underrun_q, underrun_d;

    logic       fall, busy, accept, load_data, last;
    logic [7:0] fetch_byte;
    logic [7:0] crc_hi, crc_lo;

    assign fall       = sclk_q & ~io_SpiClk;
    assign busy       = state_q != IDLE;
    assign accept     = io_ReqValid & io_ReqReady;
    // An underrun still consumes a byte slot; the host sees 0xFF in its place.
    assign fetch_byte = io_DataValid ? io_DataByte : 8'hFF;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        r1_d       = r1_q;
        flag_d     = flag_q;
        underrun_d = underrun_q;
        load_data  = 1'b0;
        last       = 1'b0;
        if (accept) begin
            r1_d       = io_ReqR1;
            flag_d     = io_ReqData;
            byte_d     = 10'd0;
            shift_d    = 8'hFF;
            bit_d      = 3'd0;
            state_d    = NCR;
            underrun_d = 1'b0;
        end else if (busy && io_CS) begin
            state_d = IDLE;
            shift_d = 8'hFF;
            bit_d   = 3'd0;
            byte_d  = 10'd0;
        end else if (busy && fall) begin
            shift_d = {shift_q[6:0], 1'b1};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
                case (state_q)
                    NCR: begin
                        if (byte_q == NCR_LAST) begin
                            state_d = R1;
                            shift_d = r1_q;
                            byte_d  = 10'd0;
                        end else begin
                            shift_d = 8'hFF;
                            byte_d  = byte_q + 10'd1;
                        end
                    end
                    R1: begin
                        if (flag_q) begin
                            state_d = TOKEN_ST;
                            shift_d = TOKEN;
                        end else begin
                            last = 1'b1;
                        end
                    end
                    TOKEN_ST: begin
                        state_d   = DATA;
                        load_data = 1'b1;
                        byte_d    = 10'd0;
                    end
                    DATA: begin
                        if (byte_q == BLK_LAST) begin
                            state_d = CRC;
                            shift_d = crc_hi;
                            byte_d  = 10'd0;
                        end else begin
                            load_data = 1'b1;
                            byte_d    = byte_q + 10'd1;
                        end
                    end
                    CRC: begin
                        if (byte_q == 10'd0) begin
                            shift_d = crc_lo;
                            byte_d  = 10'd1;
                        end else begin
                            last = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
                if (load_data) begin
                    shift_d = fetch_byte;
                    if (!io_DataValid) underrun_d = 1'b1;
                end
                if (last) begin
                    state_d = IDLE;
                    shift_d = 8'hFF;
                    byte_d  = 10'd0;
                end
            end
        end
    end

`ifdef SD_SPI_TX_CRC16_EN
    logic [15:0] crc_q, crc_d;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (accept) crc_d = 16'h0000;
        else if (load_data) crc_d = crc16_byte(crc_q, fetch_byte);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) crc_q <= 16'h0000;
        else crc_q <= crc_d;
    end

    assign crc_hi = crc_q[15:8];
    assign crc_lo = crc_q[7:0];
`else
    assign crc_hi = 8'hFF;
    assign crc_lo = 8'hFF;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sclk_q     <= 1'b0;
            ready_q    <= 1'b0;
            shift_q    <= 8'hFF;
            bit_q      <= 3'd0;
            byte_q     <= 10'd0;
            r1_q       <= 8'hFF;
            flag_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= io_SpiClk;
            ready_q    <= 1'b1;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            r1_q       <= r1_d;
            flag_q     <= flag_d;
            underrun_q <= underrun_d;
        end
    end

    assign io_ReqReady  = ready_q & ~busy & ~io_CS;
    assign io_DataReady = load_data & io_DataValid;
    assign io_DO        = busy ? shift_q[7] : 1'b1;
    assign io_Busy      = busy;
    assign io_Done      = last;
    assign io_Underrun  = underrun_q;

endmodule

// File: tb/tb_sd_spi_response_tx.sv
// Directed bench for sd_spi_response_tx with NCR_BYTES=1, BLOCK_BYTES=4.
// Define SD_SPI_TX_CRC16_EN for both files to check the real CRC bytes.
module tb_sd_spi_response_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_SpiClk;
    logic       io_CS;
    logic       io_ReqValid;
    logic       io_ReqReady;
    logic [7:0] io_ReqR1;
    logic       io_ReqData;
    logic       io_DataValid;
    logic [7:0] io_DataByte;
    logic       io_DataReady;
    logic       io_DO;
    logic       io_Busy;
    logic       io_Done;
    logic       io_Underrun;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ready_cnt = 0;
    int ready_base = 0;

    logic [7:0] data_arr [4];

    sd_spi_response_tx #(
        .NCR_BYTES  (1),
        .BLOCK_BYTES(4),
        .TOKEN      (8'hFE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_SpiClk   (io_SpiClk),
        .io_CS       (io_CS),
        .io_ReqValid (io_ReqValid),
        .io_ReqReady (io_ReqReady),
        .io_ReqR1    (io_ReqR1),
        .io_ReqData  (io_ReqData),
        .io_DataValid(io_DataValid),
        .io_DataByte (io_DataByte),
        .io_DataReady(io_DataReady),
        .io_DO       (io_DO),
        .io_Busy     (io_Busy),
        .io_Done     (io_Done),
        .io_Underrun (io_Underrun)
    );

    always #5 clock = ~clock;

    // Data source advances only when the DUT takes a byte.
    assign io_DataByte = data_arr[2'(ready_cnt - ready_base)];

    always @(posedge clock) begin
        if (io_Done) done_cnt <= done_cnt + 1;
        if (io_DataReady) ready_cnt <= ready_cnt + 1;
    end

`ifdef SD_SPI_TX_CRC16_EN
    function automatic logic [15:0] crc_model(input logic [7:0] d0, input logic [7:0] d1,
                                              input logic [7:0] d2, input logic [7:0] d3);
        logic [15:0] c;
        logic [31:0] msg;
        logic        fb;
        c   = 16'h0000;
        msg = {d0, d1, d2, d3};
        for (int i = 31; i >= 0; i--) begin
            fb = c[15] ^ msg[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction
`endif

    task automatic recv_bits(input int n, inout logic [7:0] b);
        for (int i = 0; i < n; i++) begin
            io_SpiClk = 1'b1;
            @(negedge clock);
            @(negedge clock);
            b = {b[6:0], io_DO};
            io_SpiClk = 1'b0;
            @(negedge clock);
            @(negedge clock);
        end
    endtask

    task automatic do_accept(input logic [7:0] r1, input logic dflag);
        io_ReqR1    = r1;
        io_ReqData  = dflag;
        io_ReqValid = 1'b1;
        @(negedge clock);
        io_ReqValid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (io_DO !== 1'b1 || io_Busy !== 1'b0 || io_Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: DO=%b Busy=%b Done=%b required 1 0 0", io_DO, io_Busy,
                     io_Done);
        end
        checks++;
        if (io_Underrun !== 1'b0 || io_DataReady !== 1'b0 || io_ReqReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: Underrun=%b DataReady=%b ReqReady=%b required 0 0 0",
                     io_Underrun, io_DataReady, io_ReqReady);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (io_ReqReady !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_clock: got %b required 0", io_ReqReady);
        end
        @(negedge clock);
        checks++;
        if (io_ReqReady !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_clock: got %b required 1", io_ReqReady);
        end
    endtask

    task automatic test_r1_only;
        logic [7:0] b;
        int d0;
        d0 = done_cnt;
        do_accept(8'h01, 1'b0);
        checks++;
        if (io_Busy !== 1'b1 || io_ReqReady !== 1'b0) begin
            errors++;
            $display("FAIL r1_busy: Busy=%b ReqReady=%b required 1 0", io_Busy, io_ReqReady);
        end
        b = 8'h00;
        recv_bits(8, b);
        checks++;
        if (b !== 8'hFF) begin
            errors++;
            $display("FAIL r1_ncr: got %h required ff", b);
        end
        recv_bits(8, b);
        checks++;
        if (b !== 8'h01) begin
            errors++;
            $display("FAIL r1_byte: got %h required 01", b);
        end
        checks++;
        if (done_cnt - d0 !== 1 || io_Busy !== 1'b0 || io_DO !== 1'b1) begin
            errors++;
            $display("FAIL r1_end: done=%0d Busy=%b DO=%b required 1 0 1", done_cnt - d0,
                     io_Busy, io_DO);
        end
    endtask

    // skip_second: hold DataValid low at the load point of the second data byte.
    task automatic run_block(input logic skip_second, input string tag);
        logic [7:0]  b;
        logic [7:0]  exp [9];
        logic [15:0] crc;
        int d0;
        int r0;
        data_arr[0] = 8'hDE;
        data_arr[1] = 8'hAD;
        data_arr[2] = 8'hBE;
        data_arr[3] = 8'hEF;
        ready_base   = ready_cnt;
        r0           = ready_cnt;
        d0           = done_cnt;
        io_DataValid = 1'b1;
        exp[0] = 8'hFF;
        exp[1] = 8'h00;
        exp[2] = 8'hFE;
        exp[3] = 8'hDE;
        if (skip_second) begin
            exp[4] = 8'hFF;
            exp[5] = 8'hAD;
            exp[6] = 8'hBE;
        end else begin
            exp[4] = 8'hAD;
            exp[5] = 8'hBE;
            exp[6] = 8'hEF;
        end
`ifdef SD_SPI_TX_CRC16_EN
        crc = crc_model(exp[3], exp[4], exp[5], exp[6]);
`else
        crc = 16'hFFFF;
`endif
        exp[7] = crc[15:8];
        exp[8] = crc[7:0];
        do_accept(8'h00, 1'b1);
        for (int k = 0; k < 9; k++) begin
            io_DataValid = !(skip_second && k == 3);
            b = 8'h00;
            recv_bits(8, b);
            checks++;
            if (b !== exp[k]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h required %h", tag, k, b, exp[k]);
            end
        end
        checks++;
        if (ready_cnt - r0 !== (skip_second ? 3 : 4)) begin
            errors++;
            $display("FAIL %s_ready_pulses: got %0d required %0d", tag, ready_cnt - r0,
                     skip_second ? 3 : 4);
        end
        checks++;
        if (done_cnt - d0 !== 1 || io_Busy !== 1'b0 || io_Underrun !== skip_second) begin
            errors++;
            $display("FAIL %s_end: done=%0d Busy=%b Underrun=%b required 1 0 %b", tag,
                     done_cnt - d0, io_Busy, io_Underrun, skip_second);
        end
    endtask

    task automatic test_data_block;
        run_block(1'b0, "block");
    endtask

    task automatic test_underrun;
        run_block(1'b1, "underrun");
    endtask

    task automatic test_busy_reqvalid;
        logic [7:0] b;
        int d0;
        d0 = done_cnt;
        do_accept(8'h03, 1'b0);
        checks++;
        if (io_Underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear: got %b required 0", io_Underrun);
        end
        b = 8'h00;
        recv_bits(3, b);
        io_ReqR1    = 8'h7E;
        io_ReqData  = 1'b1;
        io_ReqValid = 1'b1;
        @(negedge clock);
        checks++;
        if (io_ReqReady !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: got %b required 0", io_ReqReady);
        end
        @(negedge clock);
        io_ReqValid = 1'b0;
        recv_bits(5, b);
        checks++;
        if (b !== 8'hFF) begin
            errors++;
            $display("FAIL busy_ncr: got %h required ff", b);
        end
        recv_bits(8, b);
        checks++;
        if (b !== 8'h03 || done_cnt - d0 !== 1 || io_Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_r1: got %h done=%0d Busy=%b required 03 1 0", b, done_cnt - d0,
                     io_Busy);
        end
    endtask

    task automatic test_cs_abort;
        logic [7:0] b;
        int d0;
        d0 = done_cnt;
        do_accept(8'h01, 1'b0);
        b = 8'h00;
        recv_bits(8, b);
        b = 8'hAA;
        recv_bits(3, b);
        checks++;
        if (b !== 8'h50) begin
            errors++;
            $display("FAIL abort_r1_bits: got %h required 50", b);
        end
        io_CS = 1'b1;
        @(negedge clock);
        checks++;
        if (io_Busy !== 1'b0 || io_DO !== 1'b1 || io_ReqReady !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: Busy=%b DO=%b ReqReady=%b required 0 1 0", io_Busy,
                     io_DO, io_ReqReady);
        end
        recv_bits(2, b);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - d0);
        end
        io_CS = 1'b0;
        @(negedge clock);
        do_accept(8'h05, 1'b0);
        recv_bits(8, b);
        checks++;
        if (b !== 8'hFF) begin
            errors++;
            $display("FAIL abort_new_ncr: got %h required ff", b);
        end
        recv_bits(8, b);
        checks++;
        if (b !== 8'h05 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL abort_new_r1: got %h done=%0d required 05 1", b, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        data_arr[0] = 8'hDE;
        data_arr[1] = 8'hAD;
        data_arr[2] = 8'hBE;
        data_arr[3] = 8'hEF;
        ready_base   = ready_cnt;
        io_DataValid = 1'b1;
        do_accept(8'h00, 1'b1);
        for (int k = 0; k < 5; k++) begin
            io_DataValid = (k != 3);
            recv_bits(8, b);
        end
        io_DataValid = 1'b1;
        // First bit of 0xAD shifted out; 0 is now on DO.
        recv_bits(1, b);
        checks++;
        if (io_Busy !== 1'b1 || io_Underrun !== 1'b1 || io_DO !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: Busy=%b Underrun=%b DO=%b required 1 1 0", io_Busy,
                     io_Underrun, io_DO);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (io_DO !== 1'b1 || io_Busy !== 1'b0 || io_Underrun !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: DO=%b Busy=%b Underrun=%b required 1 0 0", io_DO,
                     io_Busy, io_Underrun);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset        = 1'b1;
        io_SpiClk    = 1'b0;
        io_CS        = 1'b0;
        io_ReqValid  = 1'b0;
        io_ReqR1     = 8'h00;
        io_ReqData   = 1'b0;
        io_DataValid = 1'b1;
        data_arr[0]  = 8'hDE;
        data_arr[1]  = 8'hAD;
        data_arr[2]  = 8'hBE;
        data_arr[3]  = 8'hEF;
        test_reset();
        test_r1_only();
        test_data_block();
        test_underrun();
        test_busy_reqvalid();
        test_cs_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
